// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone classic responder bridging CPU and hardware through TX/RX FIFOs
// with status, control and a level interrupt on programmable FIFO conditions.
module wb_mailbox #(
   parameter int DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic [31:0] tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [31:0] rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        irq_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0] tx_mem [DEPTH];
   logic [31:0] rx_mem [DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_n, rx_cnt_n;
   logic rx_irq_en, tx_irq_en, rx_en_n, tx_en_n;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic req, acc_err, ctrl_wr, tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
   logic [3:0] off;
   logic [31:0] status, rd_data;
   logic unused;
   assign unused = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_sel_i[3:1]};
   assign off = wb_adr_i[5:2];
   assign tx_full = tx_cnt == CW'(DEPTH);
   assign tx_empty = tx_cnt == '0;
   assign rx_full = rx_cnt == CW'(DEPTH);
   assign rx_empty = rx_cnt == '0;
   assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign acc_err = (off >= 4'd4) | (wb_we_i & off == 4'd0 & tx_full) | (~wb_we_i & off == 4'd1 & rx_empty);
   assign ctrl_wr = req & wb_we_i & off == 4'd3 & wb_sel_i[0];
   assign tx_push = req & wb_we_i & off == 4'd0 & ~tx_full;
   assign rx_pop = req & ~wb_we_i & off == 4'd1 & ~rx_empty;
   assign tx_flush = ctrl_wr & wb_dat_i[2];
   assign rx_flush = ctrl_wr & wb_dat_i[3];
   assign tx_pop = tx_valid_o & tx_ready_i;
   assign rx_push = rx_valid_i & ~rx_full;
   assign tx_valid_o = ~tx_empty;
   assign rx_ready_o = ~rx_full;
   assign tx_data_o = tx_mem[tx_rp];
   assign wb_rty_o = 1'b0;
   assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 4'd0, rx_empty, rx_full, tx_empty, tx_full};
   always_comb begin
      tx_cnt_n = tx_flush ? '0 : tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt_n = rx_flush ? '0 : rx_cnt + CW'(rx_push) - CW'(rx_pop);
      rx_en_n = ctrl_wr ? wb_dat_i[0] : rx_irq_en;
      tx_en_n = ctrl_wr ? wb_dat_i[1] : tx_irq_en;
      rd_data = (wb_we_i | acc_err) ? '0 :
                off == 4'd1 ? rx_mem[rx_rp] :
                off == 4'd2 ? status :
                off == 4'd3 ? {30'd0, tx_irq_en, rx_irq_en} : '0;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         tx_cnt <= '0;
         rx_cnt <= '0;
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
         irq_o <= 1'b0;
      end else begin
         wb_ack_o <= req & ~acc_err;
         wb_err_o <= req & acc_err;
         wb_dat_o <= req ? rd_data : '0;
         tx_wp <= tx_flush ? '0 : tx_wp + AW'(tx_push);
         tx_rp <= tx_flush ? '0 : tx_rp + AW'(tx_pop);
         rx_wp <= rx_flush ? '0 : rx_wp + AW'(rx_push);
         rx_rp <= rx_flush ? '0 : rx_rp + AW'(rx_pop);
         tx_cnt <= tx_cnt_n;
         rx_cnt <= rx_cnt_n;
         rx_irq_en <= rx_en_n;
         tx_irq_en <= tx_en_n;
         irq_o <= (rx_en_n & (rx_cnt_n != '0)) | (tx_en_n & (tx_cnt_n == '0));
      end
   end
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && tx_push) tx_mem[tx_wp] <= wb_dat_i;
      if (!wb_rst_i && rx_push) rx_mem[rx_wp] <= rx_data_i;
   end
endmodule

// File: tb/tb_wb_mailbox.sv
// tb_wb_mailbox: scoreboard bench; bus accesses queue expected terminations, a monitor checks them.
module tb_wb_mailbox;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o, tx_data_o, rx_data_i = '0;
   logic [3:0] wb_sel_i = 4'hF;
   logic wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
   logic wb_ack_o, wb_err_o, wb_rty_o, tx_valid_o, rx_ready_o, irq_o;
   logic tx_ready_i = 1'b0, rx_valid_i = 1'b0;
   typedef struct {logic err; logic [31:0] dat; string name;} exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   wb_mailbox #(.DEPTH(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_cti_i(3'd0), .wb_bte_i(2'd0), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
      .rx_ready_o(rx_ready_o), .irq_o(irq_o)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (wb_ack_o || wb_err_o) begin
         if (wb_ack_o && wb_err_o) begin
            checks++;
            failures++;
            $display("FAIL ack_err_both actual=1 required=0");
         end
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_term actual=ack%0b/err%0b required=none", wb_ack_o, wb_err_o);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_err"}, {31'd0, wb_err_o}, {31'd0, e.err});
            chk({e.name, "_ack"}, {31'd0, wb_ack_o}, {31'd0, ~e.err});
            chk({e.name, "_dat"}, wb_dat_o, e.dat);
         end
      end
   end
   task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input logic [3:0] sel, input logic e_err, input logic [31:0] e_dat,
                      input string name);
      sb.push_back('{e_err, e_dat, name});
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_we_i = we;
      wb_sel_i = sel;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o || wb_err_o) break;
      end
      if (!(wb_ack_o || wb_err_o)) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_term required=term", name);
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_irq", {31'd0, irq_o}, 0);
      chk("rst_tx_valid", {31'd0, tx_valid_o}, 0);
      chk("rst_rx_ready", {31'd0, rx_ready_o}, 1);
      bus(32'h08, 0, 0, 4'hF, 0, 32'h0000000A, "rst_status");
      bus(32'h00, 32'h11, 1, 4'hF, 0, 0, "tx_w11");
      bus(32'h00, 32'h22, 1, 4'h0, 0, 0, "tx_w22");
      chk("tx_head11", tx_data_o, 32'h11);
      chk("tx_valid1", {31'd0, tx_valid_o}, 1);
      tx_ready_i = 1'b1;
      tick();
      chk("tx_head22", tx_data_o, 32'h22);
      chk("tx_valid2", {31'd0, tx_valid_o}, 1);
      tick();
      chk("tx_drained", {31'd0, tx_valid_o}, 0);
      tx_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) bus(32'h00, 32'h100 + i, 1, 4'hF, 0, 0, "tx_fill");
      bus(32'h00, 32'h999, 1, 4'hF, 1, 0, "tx_full_err");
      bus(32'h08, 0, 0, 4'hF, 0, 32'h00000809, "status_txfull");
      chk("tx_head_first", tx_data_o, 32'h100);
      bus(32'h0C, 32'h4, 1, 4'hF, 0, 0, "tx_flush");
      chk("tx_flushed", {31'd0, tx_valid_o}, 0);
      bus(32'h0C, 32'h1, 1, 4'hF, 0, 0, "ctrl_rxen");
      chk("irq_idle", {31'd0, irq_o}, 0);
      rx_data_i = 32'hA5A5A5A5;
      rx_valid_i = 1'b1;
      tick();
      rx_valid_i = 1'b0;
      chk("irq_rx", {31'd0, irq_o}, 1);
      bus(32'h08, 0, 0, 4'hF, 0, 32'h00010002, "status_rx1");
      bus(32'h04, 0, 0, 4'hF, 0, 32'hA5A5A5A5, "rx_read");
      chk("irq_clr", {31'd0, irq_o}, 0);
      bus(32'h04, 0, 0, 4'hF, 1, 0, "rx_empty_err");
      rx_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data_i = 32'hB0 + i;
         tick();
      end
      rx_valid_i = 1'b0;
      chk("rx_full_ready", {31'd0, rx_ready_o}, 0);
      chk("irq_rxfull", {31'd0, irq_o}, 1);
      bus(32'h08, 0, 0, 4'hF, 0, 32'h00080006, "status_rxfull");
      bus(32'h04, 0, 0, 4'hF, 0, 32'hB0, "rx_rd0");
      bus(32'h04, 0, 0, 4'hF, 0, 32'hB1, "rx_rd1");
      chk("rx_ready_again", {31'd0, rx_ready_o}, 1);
      rx_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rx_data_i = 32'hC0 + i;
         tick();
      end
      rx_data_i = 32'hDD;
      chk("rx_refull", {31'd0, rx_ready_o}, 0);
      bus(32'h0C, 32'h8, 1, 4'hF, 0, 0, "rx_flush");
      rx_valid_i = 1'b0;
      chk("rx_flush_ready", {31'd0, rx_ready_o}, 1);
      chk("rx_flush_irq", {31'd0, irq_o}, 0);
      bus(32'h08, 0, 0, 4'hF, 0, 32'h0000000A, "status_flushed");
      bus(32'h20, 32'h5, 1, 4'hF, 1, 0, "bad_off_wr");
      bus(32'h3C, 0, 0, 4'hF, 1, 0, "bad_off_rd");
      bus(32'h08, 0, 0, 4'hF, 0, 32'h0000000A, "status_after_bad");
      bus(32'h00, 0, 0, 4'hF, 0, 0, "txdata_rd");
      bus(32'h0C, 32'h3, 1, 4'hF, 0, 0, "ctrl_w3");
      bus(32'h0C, 0, 0, 4'hF, 0, 32'h3, "ctrl_rd3");
      chk("irq_txen", {31'd0, irq_o}, 1);
      bus(32'h0C, 32'h0, 1, 4'hE, 0, 0, "ctrl_nosel");
      bus(32'h0C, 0, 0, 4'hF, 0, 32'h3, "ctrl_kept");
      bus(32'h0C, 32'h0, 1, 4'h1, 0, 0, "ctrl_clear");
      chk("irq_off", {31'd0, irq_o}, 0);
      tick();
      wb_adr_i = 32'h0;
      wb_dat_i = 32'h77;
      wb_we_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      rst = 1'b1;
      tick();
      chk("rst_mid_ack", {31'd0, wb_ack_o}, 0);
      chk("rst_mid_err", {31'd0, wb_err_o}, 0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i = 1'b0;
      rst = 1'b0;
      tick();
      chk("rst_mid_txvalid", {31'd0, tx_valid_o}, 0);
      bus(32'h08, 0, 0, 4'hF, 0, 32'h0000000A, "status_post_rst");
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_terms actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_mailbox.md
# wb_mailbox

Wishbone B4 classic-cycle responder that sits on one 64-byte slave window of the IO interconnect and bridges the CPU to a hardware peripheral through two FIFOs: a TX FIFO (CPU writes, hardware consumes) and an RX FIFO (hardware produces, CPU reads). It decodes its own register window, generates registered ack/err, exposes FIFO status, and raises a level interrupt on programmable FIFO conditions.

## Interface
- DEPTH, 8, entries per FIFO; power of two, 2..128
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address; only [5:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects; only sel[0] used (CTRL)
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  ignored; classic cycles only
- wb_bte_i  in  2  ignored
- wb_dat_o  out  32  registered read data, valid with ack
- wb_ack_o  out  1  registered normal termination
- wb_err_o  out  1  registered error termination
- wb_rty_o  out  1  tied 0
- tx_data_o  out  32  TX FIFO head (show-ahead)
- tx_valid_o  out  1  TX FIFO non-empty
- tx_ready_i  in  1  hardware pops TX head when valid&ready
- rx_data_i  in  32  hardware data to RX FIFO
- rx_valid_i  in  1  push request
- rx_ready_o  out  1  RX FIFO not full
- irq_o  out  1  registered level interrupt

## Operation
- Register map (offset = adr[5:2]*4):
  - 0x00 TXDATA: write pushes wb_dat_i (all 32 bits, sel ignored); read returns 0, ack.
  - 0x04 RXDATA: read pops, returns head; write ignored, ack.
  - 0x08 STATUS (RO): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_count, [23:16] rx_count, rest 0. Writes ignored, ack.
  - 0x0C CTRL: [0] rx_irq_en, [1] tx_irq_en (RW, updated only if sel[0]); [2] tx_flush, [3] rx_flush write-1 pulses, read as 0.
  - 0x10–0x3C: err, no side effect, dat_o 0.
- Error cases: TXDATA write while tx_full (sampled registered state, even if hardware pops same cycle) -> err, no push. RXDATA read while rx_empty -> err, dat_o 0.
- ack and err mutually exclusive, never both high.
- FIFOs: circular buffers, log2(DEPTH)-bit pointers wrapping naturally, count width log2(DEPTH)+1. Simultaneous push and pop on one FIFO: count unchanged, both occur (RX: only when not full by construction).
- Flush: empties the FIFO at the commit edge; wins over any same-cycle push or pop (push dropped, transfer still acked).
- irq_o <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty), using next-state values.
- Reset: all outputs 0 except rx_ready_o=1 one cycle after reset release is permitted as 1 during reset (value = ~rx_full = 1); FIFOs empty, CTRL = 0, tx_valid_o=0, irq_o=0.

## Timing
- Access accepted when cyc&stb&~ack&~err; termination registered next edge, high exactly one cycle; a held stb gives a 2-cycle-per-access rhythm.
- Side effects (push, pop, CTRL update, flush) commit at the same edge ack/err rises; wb_dat_o captured at that edge.
- cyc/stb dropped before termination: no effect (impossible at single-cycle latency, but no state held).
- tx_valid_o rises the cycle after the push edge; tx pop by hardware visible in STATUS next cycle.
- rx_ready_o falls in the cycle after the push that fills the FIFO; rx_valid_i while ~rx_ready_o is dropped.
- irq_o lags the causing event by one edge.
- Reset mid-access: pending termination cancelled, no side effect.

## Test plan
- After reset: read 0x08 -> ack, dat_o=0x0000000A (both empty); irq_o=0, tx_valid_o=0, rx_ready_o=1.
- Write 0x11,0x22 to 0x00, tx_ready_i=1 -> tx_data_o presents 0x11 then 0x22 on consecutive cycles, tx_valid_o then 0.
- DEPTH=8, tx_ready_i=0: 8 writes ack, 9th gets err; STATUS=0x00000809; head still first word.
- Hardware pushes 0xA5A5A5A5 with CTRL=1 -> irq_o=1; read 0x04 returns 0xA5A5A5A5 with ack; irq_o clears next cycle; second read -> err, dat_o=0.
- Fill RX to 8 (rx_ready_o=0), write CTRL=0x8 concurrent with rx_valid_i -> RX empty, rx_count=0, rx_ready_o=1.
- Access offset 0x20 -> err only; assert wb_rst_i during an access -> no ack, STATUS reads reset value.
